// File: rtl/vjtag_pkg.sv
// Shared types and command encodings for the VJTAG bus controller and its
// Avalon-MM master stage.
package vjtag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDWAIT
  } state_t;

  // Command bytes understood by the upstream JTAG controller.
  localparam logic [7:0] READ  = 8'h01;
  localparam logic [7:0] WRITE = 8'h02;
  localparam logic [7:0] RST_A = 8'hFE;
  localparam logic [7:0] RST_D = 8'hFF;

endpackage

// File: rtl/vjtag_watchdog.sv
// Per-transaction cycle counter; expired flags the last allowed cycle.
// TIMEOUT = 0 disables expiry entirely.
module vjtag_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding at LAST keeps expiry asserted if a read is accepted on the final cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/vjtag_avmm_master.sv
// Executes single-outstanding read/write requests as an Avalon-MM master,
// with a watchdog that aborts transactions a hung slave never completes.
module vjtag_avmm_master
  import vjtag_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           TIMEOUT      = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    err_timeout,
  input  logic                    err_clear
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  is_write_q, is_write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;

  logic wd_clear, wd_enable, wd_expired;
  logic timeout_hit;
  logic accept;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  vjtag_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    write_d     = write_q;
    is_write_d  = is_write_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    wd_clear    = 1'b0;
    wd_enable   = (state_q == CMD) || (state_q == RDWAIT);
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          is_write_d = req_write;
          read_d     = !req_write;
          write_d    = req_write;
          wd_clear   = 1'b1;
          state_d    = CMD;
        end
      end
      CMD: begin
        // Completion on the final counted cycle takes priority over the abort.
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = is_write_q ? IDLE : RDWAIT;
        end else if (wd_expired) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      RDWAIT: begin
        if (avm_readdatavalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = avm_readdata;
          state_d     = IDLE;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An aborted read still answers so the upstream controller never stalls.
    if (timeout_hit && !is_write_q) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = TIMEOUT_DATA;
    end

    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      is_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
      write_q     <= write_d;
      is_write_q  <= is_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_byteenable = '1;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_vjtag_avmm_master.sv
// Directed bench for vjtag_avmm_master: stimulus pushes expected read data into
// a queue that a separate monitor drains whenever rsp_valid is seen.
module tb_vjtag_avmm_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_write;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        err_timeout;
  logic        err_clear;

  int checks = 0;
  int passes = 0;
  int readCycles = 0;
  int writeCycles = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  vjtag_avmm_master #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .TIMEOUT    (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_write         (req_write),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .err_timeout       (err_timeout),
    .err_clear         (err_clear)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard monitor: every response pops one expected value; strobes are tallied.
  always @(negedge clk) begin
    if (avm_read) readCycles++;
    if (avm_write) writeCycles++;
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_rsp: got 0x%0h, expected no response", rsp_rdata);
      end else begin
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for req_ready, then issues a one-cycle request pulse.
  // Returns mid-way through the cycle after acceptance.
  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [15:0] wdata);
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_write = 1'b0;
    req_wdata = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    err_clear = 1'b0;

    // Reset state
    waitCycles(2);
    checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
    checkOutput("reset_read", 32'(avm_read), 32'd0);
    checkOutput("reset_write", 32'(avm_write), 32'd0);
    checkOutput("reset_addr", 32'(avm_address), 32'd0);
    checkOutput("reset_wdata", 32'(avm_writedata), 32'd0);
    checkOutput("reset_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset_be", 32'(avm_byteenable), 32'h3);
    checkOutput("reset_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

    // Zero-wait write
    writeCycles = 0;
    applyStimulus(16'h0040, 1'b1, 16'hA5A5);
    checkOutput("wr_strobe", 32'(avm_write), 32'd1);
    checkOutput("wr_addr", 32'(avm_address), 32'h0040);
    checkOutput("wr_data", 32'(avm_writedata), 32'hA5A5);
    checkOutput("wr_be", 32'(avm_byteenable), 32'h3);
    checkOutput("wr_ready_busy", 32'(req_ready), 32'd0);
    waitCycles(1);
    checkOutput("wr_strobe_drop", 32'(avm_write), 32'd0);
    checkOutput("wr_ready_back", 32'(req_ready), 32'd1);
    waitCycles(2);
    checkOutput("wr_strobe_cycles", 32'(writeCycles), 32'd1);

    // Read with 3 waitrequest cycles, data 2 cycles after command accept
    readCycles = 0;
    avm_waitrequest = 1'b1;
    applyStimulus(16'h0010, 1'b0, 16'h0000);
    checkOutput("rd_strobe", 32'(avm_read), 32'd1);
    checkOutput("rd_addr", 32'(avm_address), 32'h0010);
    waitCycles(3);
    avm_waitrequest = 1'b0;
    waitCycles(1);
    checkOutput("rd_strobe_drop", 32'(avm_read), 32'd0);
    waitCycles(1);
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'h1234;
    expQ.push_back(16'h1234);
    waitCycles(1);
    avm_readdatavalid = 1'b0;
    checkOutput("rd_ready_back", 32'(req_ready), 32'd1);
    waitCycles(2);
    checkOutput("rd_strobe_cycles", 32'(readCycles), 32'd4);

    // Read timeout, late data ignored, err_clear
    applyStimulus(16'h0020, 1'b0, 16'h0000);
    expQ.push_back(16'hDEAD);
    waitCycles(7);
    checkOutput("to_rd_busy", 32'(req_ready), 32'd0);
    checkOutput("to_rd_err_early", 32'(err_timeout), 32'd0);
    waitCycles(1);
    checkOutput("to_rd_err", 32'(err_timeout), 32'd1);
    checkOutput("to_rd_ready", 32'(req_ready), 32'd1);
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'hBEEF;
    waitCycles(1);
    avm_readdatavalid = 1'b0;
    waitCycles(2);
    checkOutput("to_err_sticky", 32'(err_timeout), 32'd1);
    checkOutput("late_data_rdata", 32'(rsp_rdata), 32'hDEAD);
    err_clear = 1'b1;
    waitCycles(1);
    err_clear = 1'b0;
    checkOutput("err_cleared", 32'(err_timeout), 32'd0);

    // Write with waitrequest stuck high, then a normal read
    writeCycles = 0;
    avm_waitrequest = 1'b1;
    applyStimulus(16'h0080, 1'b1, 16'h1111);
    waitCycles(7);
    checkOutput("to_wr_strobe_last", 32'(avm_write), 32'd1);
    waitCycles(1);
    checkOutput("to_wr_strobe_drop", 32'(avm_write), 32'd0);
    checkOutput("to_wr_err", 32'(err_timeout), 32'd1);
    checkOutput("to_wr_ready", 32'(req_ready), 32'd1);
    avm_waitrequest = 1'b0;
    waitCycles(2);
    checkOutput("to_wr_strobe_cycles", 32'(writeCycles), 32'd8);
    err_clear = 1'b1;
    waitCycles(1);
    err_clear = 1'b0;
    applyStimulus(16'h0030, 1'b0, 16'h0000);
    checkOutput("post_to_rd_addr", 32'(avm_address), 32'h0030);
    waitCycles(1);
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'h5678;
    expQ.push_back(16'h5678);
    waitCycles(1);
    avm_readdatavalid = 1'b0;
    checkOutput("post_to_rd_err", 32'(err_timeout), 32'd0);
    waitCycles(1);

    // Reset while waiting for read data
    applyStimulus(16'h0044, 1'b0, 16'h0000);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rst_read_drop", 32'(avm_read), 32'd0);
    checkOutput("rst_addr", 32'(avm_address), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'h7777;
    waitCycles(1);
    rst = 1'b0;
    avm_readdatavalid = 1'b0;
    waitCycles(1);
    checkOutput("rst_ready_after", 32'(req_ready), 32'd1);
    writeCycles = 0;
    applyStimulus(16'h0050, 1'b1, 16'h0F0F);
    checkOutput("rst_wr_addr", 32'(avm_address), 32'h0050);
    checkOutput("rst_wr_data", 32'(avm_writedata), 32'h0F0F);
    waitCycles(2);
    checkOutput("rst_wr_cycles", 32'(writeCycles), 32'd1);

    // Back-to-back write then read
    writeCycles = 0;
    applyStimulus(16'h0060, 1'b1, 16'h2222);
    checkOutput("b2b_wr_addr", 32'(avm_address), 32'h0060);
    applyStimulus(16'h0062, 1'b0, 16'h0000);
    checkOutput("b2b_rd_strobe", 32'(avm_read), 32'd1);
    checkOutput("b2b_rd_addr", 32'(avm_address), 32'h0062);
    waitCycles(1);
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'h3333;
    expQ.push_back(16'h3333);
    waitCycles(1);
    avm_readdatavalid = 1'b0;
    waitCycles(2);
    checkOutput("b2b_wr_cycles", 32'(writeCycles), 32'd1);
    checkOutput("pending_rsp", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
